im_downscale_avg: RTL and testbench

IM_DOWNSCALE_AVG -- requirements
Module: im_downscale_avg

---
 rtl/im_proc_pkg.sv | 31 +++
 rtl/im_downscale_avg_if.sv | 34 +++
 rtl/im_block_addr_gen.sv | 90 +++++++++
 rtl/im_downscale_avg.sv | 179 +++++++++++++++++
 tb/tb_im_downscale_avg.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/im_proc_pkg.sv
// Shared types and sizing helpers for the image
// downscaler blocks.
package im_proc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } state_e;

  typedef enum logic {
    MODE_AVG = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  // Counter/address width that stays >= 1 bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sum of scale^2 samples never overflows this.
  function automatic int acc_w(
    input int ch_w,
    input int scale
  );
    return ch_w + 2 * $clog2(scale);
  endfunction

endpackage

// File: rtl/im_downscale_avg_if.sv
// Frame-memory port bundle: read side and
// write side of the downscaler.
interface im_downscale_avg_if #(
  parameter int AW = 19,
  parameter int WA = 15,
  parameter int DW = 24
);

  logic [DW-1:0] idata_rd;
  logic [AW-1:0] oaddr_rd;
  logic          omem_rd_en;
  logic [DW-1:0] odata_wr;
  logic [WA-1:0] oaddr_wr;
  logic          omem_wr_en;

  modport master (
    input  idata_rd,
    output oaddr_rd,
    output omem_rd_en,
    output odata_wr,
    output oaddr_wr,
    output omem_wr_en
  );

  modport slave (
    output idata_rd,
    input  oaddr_rd,
    input  omem_rd_en,
    input  odata_wr,
    input  oaddr_wr,
    input  omem_wr_en
  );

endinterface

// File: rtl/im_block_addr_gen.sv
// Block/sample counters and the read/write
// address arithmetic of the downscaler.
module im_block_addr_gen
  import im_proc_pkg::*;
#(
  parameter int pIN_IM_WIDTH  = 640,
  parameter int pIN_IM_HEIGHT = 480,
  parameter int pSCALE        = 4,
  localparam int AW = cw(pIN_IM_WIDTH * pIN_IM_HEIGHT),
  localparam int OW = pIN_IM_WIDTH / pSCALE,
  localparam int OH = pIN_IM_HEIGHT / pSCALE,
  localparam int WA = cw(OW * OH)
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          iclr,
  input  logic          istep_smp,
  input  logic          istep_blk,
  input  logic          idec,
  input  logic [AW-1:0] istart_ptr,
  output logic [AW-1:0] oaddr_rd,
  output logic [WA-1:0] oaddr_wr,
  output logic          ofirst_smp,
  output logic          olast_smp,
  output logic          olast_blk
);

  localparam int SW = cw(pSCALE);
  localparam int XW = cw(OW);
  localparam int YW = cw(OH);

  logic [SW-1:0] r_q;
  logic [SW-1:0] c_q;
  logic [XW-1:0] ox_q;
  logic [YW-1:0] oy_q;

  logic c_end;
  logic ox_end;

  assign c_end  = (c_q == SW'(pSCALE - 1));
  assign ox_end = (ox_q == XW'(OW - 1));

  assign ofirst_smp = (r_q == '0) && (c_q == '0);
  assign olast_smp  = idec ||
    ((r_q == SW'(pSCALE - 1)) && c_end);
  assign olast_blk  = ox_end &&
    (oy_q == YW'(OH - 1));

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_q  <= '0;
      c_q  <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else if (iclr) begin
      r_q  <= '0;
      c_q  <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      if (istep_smp) begin
        if (olast_smp) begin
          r_q <= '0;
          c_q <= '0;
        end else if (c_end) begin
          c_q <= '0;
          r_q <= r_q + 1'b1;
        end else begin
          c_q <= c_q + 1'b1;
        end
      end
      if (istep_blk) begin
        if (ox_end) begin
          ox_q <= '0;
          oy_q <= olast_blk ? '0 : oy_q + 1'b1;
        end else begin
          ox_q <= ox_q + 1'b1;
        end
      end
    end
  end

  // Truncation to AW bits gives silent wrap.
  assign oaddr_rd = istart_ptr + AW'(
    (32'(oy_q) * pSCALE + 32'(r_q)) * pIN_IM_WIDTH
    + 32'(ox_q) * pSCALE + 32'(c_q));

  assign oaddr_wr = WA'(32'(oy_q) * OW + 32'(ox_q));

endmodule

// File: rtl/im_downscale_avg.sv
// Frame downscaler: block average or decimation
// over a latency-pL read memory.
module im_downscale_avg
  import im_proc_pkg::*;
#(
  parameter int pIN_IM_WIDTH  = 640,
  parameter int pIN_IM_HEIGHT = 480,
  parameter int pSCALE        = 4,
  parameter int pCH_NUM       = 3,
  parameter int pCH_W         = 8,
  parameter int pRD_LAT       = 1,
  localparam int AW = cw(pIN_IM_WIDTH * pIN_IM_HEIGHT)
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic [AW-1:0] idata_start_ptr,
  input  logic          istart_work,
  input  logic          imode,
  output logic          omodule_work_f,
  output logic          omodule_done_f,
  im_downscale_avg_if.master mem
);

  localparam int OW  = pIN_IM_WIDTH / pSCALE;
  localparam int OH  = pIN_IM_HEIGHT / pSCALE;
  localparam int WA  = cw(OW * OH);
  localparam int DW  = pCH_NUM * pCH_W;
  localparam int ACW = acc_w(pCH_W, pSCALE);
  localparam int SH  = 2 * $clog2(pSCALE);
  localparam int DCW = cw(pRD_LAT);

  state_e state_q;
  state_e state_d;
  mode_e  mode_q;

  logic [AW-1:0] ptr_q;
  logic [DCW-1:0] dcnt_q;
  logic [pRD_LAT-1:0] vld_q;
  logic [pRD_LAT-1:0] fst_q;
  logic [ACW-1:0] acc_q [pCH_NUM];

  logic rd_en;
  logic wr_en;
  logic clr;
  logic first_smp;
  logic last_smp;
  logic last_blk;
  logic [AW-1:0] addr_rd;
  logic [WA-1:0] addr_wr;
  logic [DW-1:0] wr_data;

  im_block_addr_gen #(
    .pIN_IM_WIDTH  (pIN_IM_WIDTH),
    .pIN_IM_HEIGHT (pIN_IM_HEIGHT),
    .pSCALE        (pSCALE)
  ) u_addr (
    .iclk       (iclk),
    .irst       (irst),
    .iclr       (clr),
    .istep_smp  (rd_en),
    .istep_blk  (wr_en),
    .idec       (mode_q == MODE_DEC),
    .istart_ptr (ptr_q),
    .oaddr_rd   (addr_rd),
    .oaddr_wr   (addr_wr),
    .ofirst_smp (first_smp),
    .olast_smp  (last_smp),
    .olast_blk  (last_blk)
  );

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (istart_work) state_d = READ;
      READ:  if (last_smp) state_d = DRAIN;
      DRAIN: begin
        if (dcnt_q == DCW'(pRD_LAT - 1))
          state_d = WRITE;
      end
      WRITE: state_d = last_blk ? DONE : READ;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en          = 1'b0;
    wr_en          = 1'b0;
    clr            = 1'b0;
    omodule_work_f = 1'b0;
    omodule_done_f = 1'b0;
    unique case (1'b1)
      state_q == IDLE:  clr = 1'b1;
      state_q == READ: begin
        rd_en          = 1'b1;
        omodule_work_f = 1'b1;
      end
      state_q == DRAIN: omodule_work_f = 1'b1;
      state_q == WRITE: begin
        wr_en          = 1'b1;
        omodule_work_f = 1'b1;
      end
      state_q == DONE:  omodule_done_f = 1'b1;
      default: clr = 1'b0;
    endcase
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      ptr_q  <= '0;
      mode_q <= MODE_AVG;
    end else if (state_q == IDLE && istart_work) begin
      ptr_q  <= idata_start_ptr;
      mode_q <= mode_e'(imode);
    end
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst)                 dcnt_q <= '0;
    else if (state_q == DRAIN) dcnt_q <= dcnt_q + 1'b1;
    else                       dcnt_q <= '0;
  end

  // Tags travel with each read so returning data
  // knows whether it opens a new block.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      vld_q <= '0;
      fst_q <= '0;
    end else begin
      vld_q[0] <= rd_en;
      fst_q[0] <= rd_en & first_smp;
      for (int i = 1; i < pRD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        fst_q[i] <= fst_q[i-1];
      end
    end
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      for (int ch = 0; ch < pCH_NUM; ch++)
        acc_q[ch] <= '0;
    end else if (vld_q[pRD_LAT-1]) begin
      for (int ch = 0; ch < pCH_NUM; ch++) begin
        if (fst_q[pRD_LAT-1])
          acc_q[ch] <= ACW'(
            mem.idata_rd[ch*pCH_W +: pCH_W]);
        else
          acc_q[ch] <= acc_q[ch] + ACW'(
            mem.idata_rd[ch*pCH_W +: pCH_W]);
      end
    end
  end

  always_comb begin
    wr_data = '0;
    for (int ch = 0; ch < pCH_NUM; ch++) begin
      if (mode_q == MODE_DEC)
        wr_data[ch*pCH_W +: pCH_W] =
          acc_q[ch][pCH_W-1:0];
      else
        wr_data[ch*pCH_W +: pCH_W] =
          pCH_W'(acc_q[ch] >> SH);
    end
  end

  assign mem.omem_rd_en = rd_en;
  assign mem.oaddr_rd   = rd_en ? addr_rd : '0;
  assign mem.omem_wr_en = wr_en;
  assign mem.oaddr_wr   = wr_en ? addr_wr : '0;
  assign mem.odata_wr   = wr_en ? wr_data : '0;

endmodule

// File: tb/tb_im_downscale_avg.sv
// Bench for im_downscale_avg: 8x8 frame, scale 4,
// two instances (read latency 1 and 3).
module tb_im_downscale_avg;
  import im_proc_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int S  = 4;
  localparam int AW = 6;
  localparam int WA = 2;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start3 = 1'b0;
  logic mode = 1'b0;
  logic [AW-1:0] ptr = '0;
  logic work1, done1, work3, done3;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  im_downscale_avg_if #(.AW(AW), .WA(WA), .DW(DW)) if1 ();
  im_downscale_avg_if #(.AW(AW), .WA(WA), .DW(DW)) if3 ();

  im_downscale_avg #(
    .pIN_IM_WIDTH(W), .pIN_IM_HEIGHT(H), .pSCALE(S),
    .pCH_NUM(3), .pCH_W(8), .pRD_LAT(1)
  ) d1 (
    .iclk(clk), .irst(rst_n),
    .idata_start_ptr(ptr), .istart_work(start1),
    .imode(mode), .omodule_work_f(work1),
    .omodule_done_f(done1), .mem(if1.master)
  );

  im_downscale_avg #(
    .pIN_IM_WIDTH(W), .pIN_IM_HEIGHT(H), .pSCALE(S),
    .pCH_NUM(3), .pCH_W(8), .pRD_LAT(3)
  ) d3 (
    .iclk(clk), .irst(rst_n),
    .idata_start_ptr(ptr), .istart_work(start3),
    .imode(mode), .omodule_work_f(work3),
    .omodule_done_f(done3), .mem(if3.master)
  );

  logic [DW-1:0] img [64];
  logic [DW-1:0] m1;
  logic [DW-1:0] m3 [3];

  always @(posedge clk) begin
    m1    <= img[if1.oaddr_rd];
    m3[0] <= img[if3.oaddr_rd];
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign if1.idata_rd = m1;
  assign if3.idata_rd = m3[2];

  logic [AW-1:0] e_rd [256];
  logic [WA-1:0] e_wa [64];
  logic [DW-1:0] e_wd [64];
  int e_wn [64];
  int n_rd, n_wr;
  int rp [2], wp [2], nrd_blk [2], first_cyc [2];
  int ndone [2], nrd_tot [2];
  logic [DW-1:0] wlog [2][16];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h @%0t",
                  nm, act, exp, $time);
  endtask

  task automatic clear_sb();
    n_rd = 0;
    n_wr = 0;
    for (int k = 0; k < 2; k++) begin
      rp[k] = 0; wp[k] = 0; nrd_blk[k] = 0;
      ndone[k] = 0; nrd_tot[k] = 0;
    end
  endtask

  // Expected reads/writes of one frame from the
  // address formula and plain per-channel means.
  task automatic add_frame(input logic md,
                           input logic [AW-1:0] p);
    int a, a0;
    int s [3];
    for (int oy = 0; oy < H / S; oy++)
      for (int ox = 0; ox < W / S; ox++) begin
        s = '{0, 0, 0};
        a0 = 0;
        for (int r = 0; r < S; r++)
          for (int c = 0; c < S; c++) begin
            if (md && (r != 0 || c != 0)) continue;
            a = (int'(p) + (oy * S + r) * W
                 + ox * S + c) % 64;
            if (r == 0 && c == 0) a0 = a;
            e_rd[n_rd] = a[AW-1:0];
            n_rd++;
            for (int ch = 0; ch < 3; ch++)
              s[ch] += int'(img[a][8*ch +: 8]);
          end
        e_wa[n_wr] = WA'(oy * (W / S) + ox);
        e_wd[n_wr] = md ? img[a0] :
          {8'(s[2] / (S * S)), 8'(s[1] / (S * S)),
           8'(s[0] / (S * S))};
        e_wn[n_wr] = md ? 1 : S * S;
        n_wr++;
      end
  endtask

  task automatic mon(input int k, input int lat,
                     input logic re,
                     input logic [AW-1:0] ra,
                     input logic we,
                     input logic [WA-1:0] wa,
                     input logic [DW-1:0] wd,
                     input logic wk, input logic dn);
    if (re) begin
      if (nrd_blk[k] == 0) first_cyc[k] = cyc;
      nrd_blk[k]++;
      nrd_tot[k]++;
      checks++;
      if (rp[k] < n_rd) begin
        passed++;
        chk("rd_addr", 32'(ra), 32'(e_rd[rp[k]]));
        rp[k]++;
      end else begin
        $display("FAIL rd_unexpected dut%0d: addr %0h, none expected",
                 k, ra);
      end
    end
    if (we) begin
      checks++;
      if (wp[k] < n_wr) begin
        passed++;
        chk("wr_addr", 32'(wa), 32'(e_wa[wp[k]]));
        chk("wr_data", 32'(wd), 32'(e_wd[wp[k]]));
        chk("blk_reads", nrd_blk[k], e_wn[wp[k]]);
        chk("blk_latency", cyc - first_cyc[k] + 1,
            e_wn[wp[k]] + lat + 1);
        chk("work_in_wr", 32'(wk), 32'd1);
        if (wp[k] < 16) wlog[k][wp[k]] = wd;
        wp[k]++;
      end else begin
        $display("FAIL wr_unexpected dut%0d: addr %0h data %0h",
                 k, wa, wd);
      end
      nrd_blk[k] = 0;
    end
    if (dn) begin
      ndone[k]++;
      chk("work_at_done", 32'(wk), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, 1, if1.omem_rd_en, if1.oaddr_rd,
        if1.omem_wr_en, if1.oaddr_wr, if1.odata_wr,
        work1, done1);
    mon(1, 3, if3.omem_rd_en, if3.oaddr_rd,
        if3.omem_wr_en, if3.oaddr_wr, if3.odata_wr,
        work3, done3);
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_d1"}, 32'(|{if1.omem_rd_en,
        if1.oaddr_rd, if1.omem_wr_en, if1.oaddr_wr,
        if1.odata_wr, work1, done1}), 32'd0);
    chk({nm, "_d3"}, 32'(|{if3.omem_rd_en,
        if3.oaddr_rd, if3.omem_wr_en, if3.oaddr_wr,
        if3.odata_wr, work3, done3}), 32'd0);
  endtask

  task automatic rand_img();
    for (int i = 0; i < 64; i++)
      img[i] = DW'($urandom);
  endtask

  task automatic run_frame(input logic md,
                           input logic [AW-1:0] p);
    bit ok;
    @(posedge clk);
    clear_sb();
    add_frame(md, p);
    @(negedge clk);
    mode = md; ptr = p; start1 = 1'b1; start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      mode = 1'($urandom);
      ptr  = AW'($urandom);
      if (ndone[0] > 0 && ndone[1] > 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_done_in_time", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("rd_all_d1", rp[0], n_rd);
    chk("rd_all_d3", rp[1], n_rd);
    chk("wr_all_d1", wp[0], n_wr);
    chk("wr_all_d3", wp[1], n_wr);
    chk("done_once_d1", ndone[0], 1);
    chk("done_once_d3", ndone[1], 1);
  endtask

  initial begin
    bit ok;
    clear_sb();
    for (int i = 0; i < 64; i++) img[i] = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst_n = 1'b1;

    // Constant pixel average.
    for (int i = 0; i < 64; i++) img[i] = 24'h204060;
    run_frame(1'b0, 6'd0);
    for (int i = 0; i < 4; i++) begin
      chk("const_avg_d1", 32'(wlog[0][i]), 32'h204060);
      chk("const_avg_d3", 32'(wlog[1][i]), 32'h204060);
    end

    // Gradient x+y: channels must not carry.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y * W + x] = {3{8'(x + y)}};
    run_frame(1'b0, 6'd0);
    chk("grad_b0", 32'(wlog[0][0]), 32'h030303);
    chk("grad_b1", 32'(wlog[0][1]), 32'h070707);
    chk("grad_b2", 32'(wlog[0][2]), 32'h070707);
    chk("grad_b3", 32'(wlog[1][3]), 32'h0B0B0B);

    // Decimate, pixel = own address.
    for (int i = 0; i < 64; i++) img[i] = DW'(i);
    run_frame(1'b1, 6'd5);
    chk("dec_b0", 32'(wlog[0][0]), 32'd5);
    chk("dec_b1", 32'(wlog[0][1]), 32'd9);
    chk("dec_b2", 32'(wlog[1][2]), 32'd37);
    chk("dec_b3", 32'(wlog[1][3]), 32'd41);
    chk("dec_rd_cnt_d1", nrd_tot[0], 4);
    chk("dec_rd_cnt_d3", nrd_tot[1], 4);

    // Base near the top of the address space.
    rand_img();
    run_frame(1'b0, 6'd61);
    chk("wrap_first_rd", 32'(e_rd[3]), 32'd0);

    for (int t = 0; t < 6; t++) begin
      rand_img();
      run_frame(1'($urandom), AW'($urandom));
    end

    // Abort mid-frame at the 10th read strobe.
    rand_img();
    @(posedge clk);
    clear_sb();
    add_frame(1'b0, 6'd17);
    @(negedge clk);
    mode = 1'b0; ptr = 6'd17;
    start1 = 1'b1; start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (nrd_tot[0] >= 10) break;
    end
    chk("rd10_reached", nrd_tot[0], 10);
    #1 rst_n = 1'b0;
    #1 chk_zero("abort_now");
    chk("abort_no_wr_d1", wp[0], 0);
    chk("abort_no_done_d1", ndone[0], 0);
    repeat (4) @(negedge clk);
    chk_zero("abort_hold");
    rst_n = 1'b1;
    @(posedge clk);
    clear_sb();
    repeat (12) @(negedge clk);
    #1;
    chk("quiet_after_abort",
        nrd_tot[0] + nrd_tot[1] + wp[0] + wp[1]
        + ndone[0] + ndone[1], 0);
    rand_img();
    run_frame(1'b0, 6'd17);

    // Start held high: two back-to-back frames.
    rand_img();
    @(posedge clk);
    clear_sb();
    add_frame(1'b0, 6'd9);
    add_frame(1'b0, 6'd9);
    @(negedge clk);
    mode = 1'b0; ptr = 6'd9;
    start1 = 1'b1; start3 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (ndone[0] >= 2) start1 = 1'b0;
      if (ndone[1] >= 2) start3 = 1'b0;
      if (!start1 && !start3) begin
        ok = 1'b1;
        break;
      end
    end
    start1 = 1'b0; start3 = 1'b0;
    chk("b2b_in_time", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("b2b_done_d1", ndone[0], 2);
    chk("b2b_done_d3", ndone[1], 2);
    chk("b2b_rd_d3", rp[1], n_rd);
    chk("b2b_wr_d3", wp[1], n_wr);
    chk("b2b_wr_d1", wp[0], n_wr);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
